pipelined_inst_mem: RTL and testbench



---
 rtl/pipelined_inst_mem.sv | 131 +++++++++++++
 tb/tb_pipelined_inst_mem.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_inst_mem.sv
// Fixed-latency pipelined instruction memory. It takes val/rdy read requests and returns
// responses in order through a credit-limited response FIFO. It also has a preload write port.
module pipelined_inst_mem #(
  parameter int p_addr_bits   = 32,
  parameter int p_data_bits   = 32,
  parameter int p_depth_words = 256,
  parameter int p_latency     = 2,
  parameter int p_opaque_bits = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [p_addr_bits-1:0]   req_addr,
  input  logic [p_opaque_bits-1:0] req_opaque,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [p_data_bits-1:0]   resp_data,
  output logic [p_opaque_bits-1:0] resp_opaque,
  input  logic                     init_en,
  input  logic [p_addr_bits-1:0]   init_addr,
  input  logic [p_data_bits-1:0]   init_data,
  output logic                     err
);

  localparam int C  = p_latency + 1;
  localparam int MW = $clog2(p_depth_words);
  localparam int IW = $clog2(C);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(C + 1);

  typedef struct packed {
    logic                     valid;
    logic                     bad;
    logic [p_data_bits-1:0]   data;
    logic [p_opaque_bits-1:0] opaque;
  } stage_t;

  typedef struct packed {
    logic                     bad;
    logic [p_data_bits-1:0]   data;
    logic [p_opaque_bits-1:0] opaque;
  } entry_t;

  logic [p_data_bits-1:0] mem [p_depth_words];
  entry_t                 fifo_mem [C];

  logic [CW-1:0] outstanding;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_occ;
  logic [PW-1:0] wptr, rptr;
  logic          req_acc, resp_xfer, req_bad, init_ok;
  stage_t        s_in, s_out;
  entry_t        head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(C - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [IW-1:0] slot(input logic [PW-1:0] p);
    return IW'(p % PW'(C));
  endfunction

  // Credit check uses registered state only, so req_rdy never depends on resp_rdy.
  assign req_rdy   = (outstanding < CW'(C));
  assign req_acc   = req_val && req_rdy;
  assign fifo_occ  = outstanding - inflight;
  assign resp_val  = (fifo_occ != '0);
  assign head      = fifo_mem[slot(rptr)];
  assign resp_data   = head.data;
  assign resp_opaque = head.opaque;
  assign resp_xfer = resp_val && resp_rdy;

  assign req_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> (MW + 2)) != '0);
  assign init_ok = init_en && (init_addr[1:0] == 2'b00) && ((init_addr >> (MW + 2)) == '0);

  // Stage 1 is the acceptance cycle. The array read happens here, before any write at the same edge.
  always_comb begin
    s_in.valid  = req_acc;
    s_in.bad    = req_bad;
    s_in.data   = req_bad ? '0 : mem[req_addr[MW+1:2]];
    s_in.opaque = req_opaque;
  end

  if (p_latency == 1) begin : g_direct
    assign s_out    = s_in;
    assign inflight = '0;
  end else begin : g_delay
    stage_t dly [p_latency-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < p_latency - 1; k++) dly[k] <= '0;
      end else begin
        dly[0] <= s_in;
        for (int k = 1; k < p_latency - 1; k++) dly[k] <= dly[k-1];
      end
    end

    assign s_out = dly[p_latency-2];

    always_comb begin
      inflight = '0;
      for (int k = 0; k < p_latency - 1; k++) inflight = inflight + CW'(dly[k].valid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      wptr        <= '0;
      rptr        <= '0;
      err         <= 1'b0;
    end else begin
      if (req_acc && !resp_xfer)      outstanding <= outstanding + CW'(1);
      else if (!req_acc && resp_xfer) outstanding <= outstanding - CW'(1);
      if (s_out.valid) wptr <= ptr_next(wptr);
      if (resp_xfer) begin
        rptr <= ptr_next(rptr);
        if (head.bad) err <= 1'b1;
      end
    end
  end

  // NOTE: storage arrays have no reset. Their contents survive rst, and only the valid/pointer state is cleared.
  always_ff @(posedge clk) begin
    if (init_ok) mem[init_addr[MW+1:2]] <= init_data;
    if (s_out.valid) fifo_mem[slot(wptr)] <= '{bad: s_out.bad, data: s_out.data, opaque: s_out.opaque};
  end

endmodule

// File: tb/tb_pipelined_inst_mem.sv
// Directed bench for pipelined_inst_mem (default parameters, latency 2). It covers latency,
// throughput, backpressure, bad addresses, read-before-write preload and mid-flight reset.
module tb_pipelined_inst_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_opaque = '0;
  logic        resp_val;
  logic        resp_rdy = 1'b0;
  logic [31:0] resp_data;
  logic [7:0]  resp_opaque;
  logic        init_en = 1'b0;
  logic [31:0] init_addr = '0;
  logic [31:0] init_data = '0;
  logic        err;

  int errors = 0;
  int checks = 0;
  int accepted;
  logic [31:0] words [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_8193};

  pipelined_inst_mem dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr), .req_opaque(req_opaque),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_opaque(resp_opaque),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic [7:0] t);
    req_val    = v;
    req_addr   = a;
    req_opaque = t;
  endtask

  // Issues a single request with resp_rdy=1, then checks the response two cycles later.
  task automatic read_check(input string tag, input logic [31:0] a, input logic [7:0] t,
                            input logic [31:0] exp);
    drive_req(1'b1, a, t);
    tick();
    drive_req(1'b0, '0, '0);
    tick();
    check({tag, "_val"},    64'(resp_val),    64'(1));
    check({tag, "_data"},   64'(resp_data),   64'(exp));
    check({tag, "_opaque"}, 64'(resp_opaque), 64'(t));
    tick();
  endtask

  initial begin
    // Preload words 0..3 while in reset.
    for (int i = 0; i < 4; i++) begin
      init_en   = 1'b1;
      init_addr = 32'(i * 4);
      init_data = words[i];
      tick();
    end
    init_en = 1'b0;
    check("rst_resp_val", 64'(resp_val), 64'(0));
    check("rst_err",      64'(err),      64'(0));
    rst = 1'b0;
    tick();
    check("rst_req_rdy",  64'(req_rdy),  64'(1));

    // First request: accepted in cycle t, visible in cycle t+2.
    resp_rdy = 1'b1;
    drive_req(1'b1, 32'h0, 8'h05);
    tick();
    drive_req(1'b0, '0, '0);
    check("lat_early_val", 64'(resp_val),    64'(0));
    tick();
    check("lat_val",       64'(resp_val),    64'(1));
    check("lat_data",      64'(resp_data),   64'(32'h0000_0013));
    check("lat_opaque",    64'(resp_opaque), 64'(8'h05));
    tick();
    check("lat_drained",   64'(resp_val),    64'(0));

    // Back-to-back requests at full throughput.
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 32'(i * 4), 8'(8'h10 + i));
      check("tput_req_rdy", 64'(req_rdy), 64'(1));
      if (i >= 2) begin
        check("tput_val",  64'(resp_val),  64'(1));
        check("tput_data", 64'(resp_data), 64'(words[i-2]));
        check("tput_tag",  64'(resp_opaque), 64'(8'h10 + i - 2));
      end
      tick();
    end
    drive_req(1'b0, '0, '0);
    for (int i = 2; i < 4; i++) begin
      check("tput_val",  64'(resp_val),  64'(1));
      check("tput_data", 64'(resp_data), 64'(words[i]));
      check("tput_tag",  64'(resp_opaque), 64'(8'h10 + i));
      tick();
    end
    check("tput_drained", 64'(resp_val), 64'(0));

    // Backpressure: keep requesting until the credit limit closes req_rdy.
    resp_rdy = 1'b0;
    accepted = 0;
    for (int k = 0; k < 10; k++) begin
      if (!req_rdy) break;
      drive_req(1'b1, 32'(accepted * 4), 8'(8'h20 + accepted));
      tick();
      accepted++;
    end
    drive_req(1'b0, '0, '0);
    check("stall_accepted", 64'(accepted), 64'(3));
    tick();
    check("stall_val",     64'(resp_val),    64'(1));
    check("stall_data",    64'(resp_data),   64'(words[0]));
    check("stall_tag",     64'(resp_opaque), 64'(8'h20));
    check("stall_req_rdy", 64'(req_rdy),     64'(0));
    tick();
    check("stall_hold_val",  64'(resp_val),    64'(1));
    check("stall_hold_data", 64'(resp_data),   64'(words[0]));
    check("stall_hold_tag",  64'(resp_opaque), 64'(8'h20));
    resp_rdy = 1'b1;
    tick();
    check("drain1_data", 64'(resp_data),   64'(words[1]));
    check("drain1_tag",  64'(resp_opaque), 64'(8'h21));
    tick();
    check("drain2_data", 64'(resp_data),   64'(words[2]));
    check("drain2_tag",  64'(resp_opaque), 64'(8'h22));
    tick();
    check("drain_done_val", 64'(resp_val), 64'(0));
    check("drain_req_rdy",  64'(req_rdy),  64'(1));

    // Misaligned and out-of-range requests.
    resp_rdy = 1'b0;
    drive_req(1'b1, 32'h2, 8'h31);
    tick();
    drive_req(1'b1, 32'h400, 8'h32);
    tick();
    drive_req(1'b0, '0, '0);
    check("bad1_val",    64'(resp_val),    64'(1));
    check("bad1_data",   64'(resp_data),   64'(0));
    check("bad1_tag",    64'(resp_opaque), 64'(8'h31));
    check("err_before",  64'(err),         64'(0));
    resp_rdy = 1'b1;
    tick();
    check("err_after",   64'(err),         64'(1));
    check("bad2_val",    64'(resp_val),    64'(1));
    check("bad2_data",   64'(resp_data),   64'(0));
    check("bad2_tag",    64'(resp_opaque), 64'(8'h32));
    tick();
    check("bad_drained", 64'(resp_val),    64'(0));
    read_check("good_after_bad", 32'h8, 8'h33, words[2]);
    check("err_sticky",  64'(err),         64'(1));

    // Same-cycle preload and read of word 1: the read sees the old value.
    init_en   = 1'b1;
    init_addr = 32'h4;
    init_data = 32'hDEAD_BEEF;
    drive_req(1'b1, 32'h4, 8'h41);
    tick();
    init_en = 1'b0;
    drive_req(1'b0, '0, '0);
    tick();
    check("rbw_old_data", 64'(resp_data),   64'(32'h0010_0093));
    check("rbw_old_tag",  64'(resp_opaque), 64'(8'h41));
    tick();
    read_check("rbw_new", 32'h4, 8'h42, 32'hDEAD_BEEF);

    // Reset with two requests in flight.
    drive_req(1'b1, 32'h0, 8'h51);
    tick();
    drive_req(1'b1, 32'h8, 8'h52);
    tick();
    drive_req(1'b0, '0, '0);
    check("pre_rst_val", 64'(resp_val), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_async_val",     64'(resp_val), 64'(0));
    check("rst_async_req_rdy", 64'(req_rdy),  64'(1));
    check("rst_async_err",     64'(err),      64'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_stale_val", 64'(resp_val), 64'(0));
    end
    check("post_rst_req_rdy", 64'(req_rdy), 64'(1));

    // Illegal preloads are ignored and do not set err.
    init_en   = 1'b1;
    init_addr = 32'h400;
    init_data = 32'hFFFF_FFFF;
    tick();
    init_addr = 32'h2;
    tick();
    init_en = 1'b0;
    read_check("post_rst_w0", 32'h0, 8'h61, words[0]);
    read_check("post_rst_w1", 32'h4, 8'h62, 32'hDEAD_BEEF);
    read_check("post_rst_w3", 32'hC, 8'h63, words[3]);
    check("init_bad_no_err", 64'(err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
